// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types, counter encodings and helpers for the branch predictor
//
// Purpose: 2-bit pattern-history counter encodings, predictor state enum,
// PHT update opcodes and saturating counter helpers.
// Ports: none (package).
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_e;

  // Operation applied by the PHT read-modify-write port.
  typedef enum logic [1:0] {
    PHT_INC,
    PHT_DEC,
    PHT_SET_WT
  } pht_op_e;

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and ID resolution bundle for the branch predictor
//
// Purpose: groups the fetch-side lookup, the prediction outputs and the
// ID-stage resolution feedback into one bundle.
// Ports (signals):
//   pc_if, fetch_en                   fetch PC and IF/ID advance qualifier
//   pred_taken, pred_target, pred_ghr prediction and GHR snapshot
//   upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
//   upd_mispredict, upd_ghr           resolution of a branch/jump in ID
//   init_done                         table sweep finished
// Modports: master = CPU pipeline, slave = predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6
);

  logic [ADDR_W-1:0] pc_if;
  logic              fetch_en;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic [IDX_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_cond;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [IDX_W-1:0]  upd_ghr;
  logic              init_done;

  modport master (
    output pc_if, fetch_en,
    output upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_mispredict, upd_ghr,
    input  pred_taken, pred_target, pred_ghr, init_done
  );

  modport slave (
    input  pc_if, fetch_en,
    input  upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_mispredict, upd_ghr,
    output pred_taken, pred_target, pred_ghr, init_done
  );

endinterface

// File: rtl/bp_pht.sv
// rtl/bp_pht.sv - 2-bit saturating pattern history table
//
// Purpose: counter array with a combinational lookup read port, a
// read-modify-write update port and a sweep-clear port.
// Ports:
//   clk                      clock
//   rd_idx / rd_ctr          lookup index and counter value (combinational)
//   upd_en, upd_idx, upd_op  update strobe, index and operation
//   clr_en, clr_idx          sweep clear: sets the counter to WNT
module bp_pht
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  pht_op_e          upd_op,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  logic [ENTRIES-1:0][1:0] ctr_q;
  logic [ENTRIES-1:0][1:0] ctr_d;

  // Lookup reads the registered array, so a same-cycle update is not seen.
  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (clr_en) begin
      ctr_d[clr_idx] = CTR_WNT;
    end else if (upd_en) begin
      case (upd_op)
        PHT_INC:    ctr_d[upd_idx] = ctr_inc(ctr_q[upd_idx]);
        PHT_DEC:    ctr_d[upd_idx] = ctr_dec(ctr_q[upd_idx]);
        PHT_SET_WT: ctr_d[upd_idx] = CTR_WT;
        default:    ctr_d[upd_idx] = ctr_q[upd_idx];
      endcase
    end
  end

  // Contents are initialised by the sweep, not by reset.
  always_ff @(posedge clk) begin
    ctr_q <= ctr_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB + 2-bit PHT dynamic branch predictor (bimodal or gshare)
//
// Purpose: predicts direction and target for the fetch PC from a direct-mapped
// BTB and a PHT, trained by branch/jump resolutions reported from ID.
// Ports:
//   clk     clock
//   reset   synchronous active-high reset; restarts the table sweep
//   bp      branch_predictor_if.slave: lookup, prediction, update, init_done
// Parameters: ENTRIES (power of two, >= 4), MODE (0 bimodal, 1 gshare), ADDR_W.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int MODE    = 0,
  parameter int ADDR_W  = 32
) (
  input  logic            clk,
  input  logic            reset,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // ---------------------------------------------------------------- state
  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [IDX_W-1:0] ghr_q, ghr_d;

  logic [ENTRIES-1:0]             btb_valid_q, btb_valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]  btb_tag_q, btb_tag_d;
  logic [ENTRIES-1:0][ADDR_W-1:0] btb_target_q, btb_target_d;
  logic [ENTRIES-1:0]             btb_cond_q, btb_cond_d;

  logic run;
  logic sweep_en;

  // ------------------------------------------------------------ FSM: regs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BP_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // BTB payload is not reset; the sweep clears every valid bit instead.
  always_ff @(posedge clk) begin
    btb_valid_q  <= btb_valid_d;
    btb_tag_q    <= btb_tag_d;
    btb_target_q <= btb_target_d;
    btb_cond_q   <= btb_cond_d;
  end

  // ------------------------------------------------------ FSM: next state
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      BP_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == IDX_W'(ENTRIES - 1)) begin
          state_d = BP_RUN;
        end
      end
      BP_RUN:  state_d = BP_RUN;
      default: state_d = BP_INIT;
    endcase
  end

  // --------------------------------------------------------- FSM: outputs
  always_comb begin
    run      = 1'b0;
    sweep_en = 1'b0;
    case (state_q)
      BP_INIT: sweep_en = 1'b1;
      BP_RUN:  run      = 1'b1;
      default: sweep_en = 1'b1;
    endcase
  end

  assign bp.init_done = run;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_pht_idx;
  logic [1:0]       lk_ctr;
  logic             lk_hit;
  logic             lk_cond;

  assign lk_idx     = bp.pc_if[IDX_W+1:2];
  assign lk_tag     = bp.pc_if[ADDR_W-1:IDX_W+2];
  assign lk_pht_idx = (MODE != 0) ? (lk_idx ^ ghr_q) : lk_idx;
  assign lk_hit     = run && btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign lk_cond    = btb_cond_q[lk_idx];

  assign bp.pred_taken  = lk_hit && (!lk_cond || lk_ctr[1]);
  assign bp.pred_target = bp.pred_taken ? btb_target_q[lk_idx] : bp.pc_if + ADDR_W'(4);
  assign bp.pred_ghr    = ghr_q;

  // ---------------------------------------------------------------- update
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_en;
  logic [IDX_W-1:0] up_pht_idx;
  logic             pht_upd_en;
  pht_op_e          pht_upd_op;

  assign up_idx     = bp.upd_pc[IDX_W+1:2];
  assign up_tag     = bp.upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit     = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
  assign up_en      = run && bp.upd_valid;
  // In gshare mode the counter trained is the one the lookup used, so the
  // snapshot carried with the instruction is folded in, not the live GHR.
  assign up_pht_idx = (MODE != 0) ? (up_idx ^ bp.upd_ghr) : up_idx;

  always_comb begin
    btb_valid_d  = btb_valid_q;
    btb_tag_d    = btb_tag_q;
    btb_target_d = btb_target_q;
    btb_cond_d   = btb_cond_q;
    pht_upd_en   = 1'b0;
    pht_upd_op   = PHT_INC;
    if (sweep_en) begin
      btb_valid_d[sweep_q] = 1'b0;
    end else if (up_en) begin
      if (up_hit) begin
        btb_target_d[up_idx] = bp.upd_target;
        btb_cond_d[up_idx]   = bp.upd_is_cond;
        if (bp.upd_is_cond) begin
          pht_upd_en = 1'b1;
          pht_upd_op = bp.upd_taken ? PHT_INC : PHT_DEC;
        end
      end else if (bp.upd_taken) begin
        // Allocation overwrites whatever aliased entry was there.
        btb_valid_d[up_idx]  = 1'b1;
        btb_tag_d[up_idx]    = up_tag;
        btb_target_d[up_idx] = bp.upd_target;
        btb_cond_d[up_idx]   = bp.upd_is_cond;
        if (bp.upd_is_cond) begin
          pht_upd_en = 1'b1;
          pht_upd_op = PHT_SET_WT;
        end
      end
    end
  end

  bp_pht #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_pht (
    .clk     (clk),
    .rd_idx  (lk_pht_idx),
    .rd_ctr  (lk_ctr),
    .upd_en  (pht_upd_en),
    .upd_idx (up_pht_idx),
    .upd_op  (pht_upd_op),
    .clr_en  (sweep_en),
    .clr_idx (sweep_q)
  );

  // ------------------------------------------------------------------- GHR
  // A resolved mispredict rebuilds history from the instruction's snapshot
  // and wins over any speculative shift from the current fetch.
  always_comb begin
    ghr_d = ghr_q;
    if ((MODE == 0) || !run) begin
      ghr_d = '0;
    end else if (bp.upd_valid && bp.upd_mispredict) begin
      ghr_d = bp.upd_is_cond ? {bp.upd_ghr[IDX_W-2:0], bp.upd_taken} : bp.upd_ghr;
    end else if (bp.fetch_en && lk_hit && lk_cond) begin
      ghr_d = {ghr_q[IDX_W-2:0], bp.pred_taken};
    end
  end

  // Low PC bits are word-offset bits and never index or tag the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_if[1:0], bp.upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed scoreboard bench for branch_predictor (bimodal and gshare)
module tb_branch_predictor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(32), .IDX_W(4)) bp0 ();
  branch_predictor_if #(.ADDR_W(32), .IDX_W(4)) bp1 ();

  branch_predictor #(.ENTRIES(16), .MODE(0), .ADDR_W(32)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bp    (bp0)
  );

  branch_predictor #(.ENTRIES(16), .MODE(1), .ADDR_W(32)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bp    (bp1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic        taken;
    logic [31:0] target;
    logic [3:0]  ghr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    bp0.pc_if = 32'h100; bp0.fetch_en = 1'b0; bp0.upd_valid = 1'b0; bp0.upd_pc = '0;
    bp0.upd_is_cond = 1'b0; bp0.upd_taken = 1'b0; bp0.upd_target = '0;
    bp0.upd_mispredict = 1'b0; bp0.upd_ghr = '0;
    bp1.pc_if = 32'h100; bp1.fetch_en = 1'b0; bp1.upd_valid = 1'b0; bp1.upd_pc = '0;
    bp1.upd_is_cond = 1'b0; bp1.upd_taken = 1'b0; bp1.upd_target = '0;
    bp1.upd_mispredict = 1'b0; bp1.upd_ghr = '0;
  endtask

  // Counts cycles from the current drive point until init_done, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (!bp0.init_done && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One pipeline cycle: drive lookup and optional update, queue the expected
  // prediction, compare it at the falling edge, then step past the rising edge.
  task automatic cyc(input int sel, input logic [31:0] pc, input logic fen,
                     input logic uv, input logic [31:0] upc, input logic ucond,
                     input logic utaken, input logic [31:0] utgt, input logic umis,
                     input logic [3:0] ughr, input logic etaken, input logic [31:0] etgt,
                     input logic [3:0] eghr, input string tag);
    exp_t e;
    exp_t got;
    logic        o_taken;
    logic [31:0] o_tgt;
    logic [3:0]  o_ghr;
    if (sel == 0) begin
      bp0.pc_if = pc; bp0.fetch_en = fen; bp0.upd_valid = uv; bp0.upd_pc = upc;
      bp0.upd_is_cond = ucond; bp0.upd_taken = utaken; bp0.upd_target = utgt;
      bp0.upd_mispredict = umis; bp0.upd_ghr = ughr;
    end else begin
      bp1.pc_if = pc; bp1.fetch_en = fen; bp1.upd_valid = uv; bp1.upd_pc = upc;
      bp1.upd_is_cond = ucond; bp1.upd_taken = utaken; bp1.upd_target = utgt;
      bp1.upd_mispredict = umis; bp1.upd_ghr = ughr;
    end
    e.tag = tag; e.sel = sel; e.taken = etaken; e.target = etgt; e.ghr = eghr;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    o_taken = (got.sel == 0) ? bp0.pred_taken  : bp1.pred_taken;
    o_tgt   = (got.sel == 0) ? bp0.pred_target : bp1.pred_target;
    o_ghr   = (got.sel == 0) ? bp0.pred_ghr    : bp1.pred_ghr;
    chk({got.tag, "_taken"},  32'(o_taken), 32'(got.taken));
    chk({got.tag, "_target"}, o_tgt, got.target);
    chk({got.tag, "_ghr"},    32'(o_ghr), 32'(got.ghr));
    @(posedge clk); #1;
    bp0.upd_valid = 1'b0;
    bp1.upd_valid = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    idle_all();
    @(posedge clk); #1;

    // Reset values on both instances.
    chk("rst_init_done0", 32'(bp0.init_done), 32'd0);
    chk("rst_taken0",     32'(bp0.pred_taken), 32'd0);
    chk("rst_target0",    bp0.pred_target, 32'h104);
    chk("rst_ghr0",       32'(bp0.pred_ghr), 32'd0);
    chk("rst_init_done1", 32'(bp1.init_done), 32'd0);
    chk("rst_taken1",     32'(bp1.pred_taken), 32'd0);
    chk("rst_target1",    bp1.pred_target, 32'h104);
    chk("rst_ghr1",       32'(bp1.pred_ghr), 32'd0);

    // Sweep length, then a restart part-way through the sweep.
    reset = 1'b0;
    wait_init(n);
    chk("sweep_len", 32'(n), 32'd16);
    chk("sweep_done1", 32'(bp1.init_done), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("mid_sweep_low", 32'(bp0.init_done), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init(n);
    chk("sweep_restart_len", 32'(n), 32'd16);

    // ---------------- bimodal instance
    //  sel pc            fen uv upc           c  t  utgt          mis ghr   etk etgt          eghr
    cyc(0, 32'h40,  1'b1, 1, 32'h40, 1, 1, 32'h80,  1, 4'h0, 0, 32'h44,  4'h0, "same_cycle");
    cyc(0, 32'h40,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h80,  4'h0, "alloc");
    cyc(0, 32'h40,  1'b0, 1, 32'h40, 1, 0, 32'h80,  0, 4'h0, 1, 32'h80,  4'h0, "nt_pre");
    cyc(0, 32'h40,  1'b0, 1, 32'h40, 1, 0, 32'h80,  0, 4'h0, 0, 32'h44,  4'h0, "ctr_wnt");
    cyc(0, 32'h40,  1'b0, 1, 32'h40, 1, 0, 32'h80,  0, 4'h0, 0, 32'h44,  4'h0, "ctr_snt");
    cyc(0, 32'h40,  1'b0, 1, 32'h40, 1, 1, 32'h80,  0, 4'h0, 0, 32'h44,  4'h0, "ctr_sat");
    cyc(0, 32'h40,  1'b0, 1, 32'h40, 1, 1, 32'h80,  0, 4'h0, 0, 32'h44,  4'h0, "ctr_up_wnt");
    cyc(0, 32'h40,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h80,  4'h0, "ctr_up_wt");
    cyc(0, 32'h440, 1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 0, 32'h444, 4'h0, "tag_alias");
    cyc(0, 32'h10,  1'b1, 1, 32'h10, 0, 1, 32'h200, 1, 4'h5, 0, 32'h14,  4'h0, "jump_pre");
    cyc(0, 32'h10,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h200, 4'h0, "jump");
    cyc(0, 32'h40,  1'b1, 1, 32'h10, 0, 1, 32'h200, 0, 4'h0, 1, 32'h80,  4'h0, "bimodal_ghr");
    cyc(0, 32'h10,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h200, 4'h0, "jump_hit");

    // Reset while running clears the BTB again.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_init(n);
    chk("run_reset_len", 32'(n), 32'd16);
    cyc(0, 32'h40,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 0, 32'h44,  4'h0, "swept");

    // ---------------- gshare instance
    cyc(1, 32'hF00, 1'b0, 1, 32'h40, 1, 1, 32'h80,  0, 4'h0, 0, 32'hF04, 4'h0, "gs_alloc");
    cyc(1, 32'hF00, 1'b0, 1, 32'h40, 1, 1, 32'h80,  0, 4'h1, 0, 32'hF04, 4'h0, "gs_train");
    cyc(1, 32'h40,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h80,  4'h0, "gs_hit0");
    cyc(1, 32'h40,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h80,  4'h1, "gs_hit1");
    cyc(1, 32'h40,  1'b0, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 0, 32'h44,  4'h3, "gs_ghr11");
    cyc(1, 32'h40,  1'b0, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 0, 32'h44,  4'h3, "gs_hold");
    cyc(1, 32'h40,  1'b1, 1, 32'h40, 1, 0, 32'h80,  1, 4'h5, 0, 32'h44,  4'h3, "gs_prio_pre");
    cyc(1, 32'hF00, 1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 0, 32'hF04, 4'hA, "gs_mispredict");
    cyc(1, 32'hF00, 1'b1, 1, 32'h10, 0, 1, 32'h200, 1, 4'h6, 0, 32'hF04, 4'hA, "gs_jump_pre");
    cyc(1, 32'h10,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h200, 4'h6, "gs_jump_restore");
    cyc(1, 32'h10,  1'b1, 0, 32'h0,  0, 0, 32'h0,   0, 4'h0, 1, 32'h200, 4'h6, "gs_uncond_noshift");

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It predicts direction and target in IF with a direct-mapped branch target buffer (BTB) and a 2-bit saturating pattern history table (PHT), in bimodal or gshare mode. It is trained by the branch/jump resolution produced in ID. It replaces the static "fall through, flush on taken" policy; the CPU still flushes IF/ID on mispredict.

## Interface

Parameters:
- `ENTRIES`, 64: BTB and PHT depth; power of two, ≥ 4. `IDX_W` = log2(`ENTRIES`).
- `MODE`, 0: 0 = bimodal (PHT index = PC index); 1 = gshare (PHT index = PC index XOR GHR).
- `ADDR_W`, 32: PC width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; one clock.
- `pc_if`  in  `ADDR_W`  fetch PC.
- `fetch_en`  in  1  low while IF/ID is held; blocks speculative GHR update.
- `pred_taken`  out  1  predict redirect.
- `pred_target`  out  `ADDR_W`  predicted next PC.
- `pred_ghr`  out  `IDX_W`  GHR snapshot; the CPU carries it with the instruction to ID.
- `upd_valid`  in  1  branch/`j`/`jal` resolved in ID this cycle; `jr`/`jalr` are never reported.
- `upd_pc`  in  `ADDR_W`  PC of the resolved instruction.
- `upd_is_cond`  in  1  1 = conditional branch, 0 = unconditional jump.
- `upd_taken`  in  1  actual direction.
- `upd_target`  in  `ADDR_W`  actual target.
- `upd_mispredict`  in  1  prediction was wrong (direction or target).
- `upd_ghr`  in  `IDX_W`  `pred_ghr` snapshot taken for this instruction.
- `init_done`  out  1  high once the table sweep has completed.

## Operation

- **Index and tag.** Index = `pc[IDX_W+1:2]`. Tag = `pc[ADDR_W-1:IDX_W+2]`.
- **BTB entry.** Each entry holds `valid`, `tag`, `target`, `is_cond`. The PHT holds 2-bit counters: 00 SNT, 01 WNT, 10 WT, 11 ST.
- **State machine.**
  - INIT: entered on reset. A sweep counter clears one BTB valid bit per cycle and sets that PHT counter to WNT, covering indices 0..`ENTRIES`-1. Then go to RUN.
  - Reset asserted mid-sweep or in RUN restarts the sweep at index 0.
  - While in INIT: `pred_taken`=0, updates are ignored, GHR is held at 0.
- **Lookup (RUN, combinational on `pc_if`).**
  - Hit = valid and tag match.
  - `pred_taken` = hit AND (NOT `is_cond` OR PHT counter MSB).
  - `pred_target` = BTB target if `pred_taken`, else `pc_if`+4, modulo 2^`ADDR_W`.
  - `pred_ghr` = current GHR.
- **Update (RUN, at posedge when `upd_valid`).**
  - BTB hit on `upd_pc`: rewrite `target` and `is_cond`. If conditional, the counter saturating-increments when taken and decrements when not taken. The PHT index uses `upd_ghr` in gshare mode.
  - BTB miss and taken: allocate (overwrite) the entry. The counter is set to WT for a conditional branch; for a jump the counter is left untouched.
  - BTB miss and not taken: no write.
- **GHR** (`IDX_W` bits; always 0 when `MODE`=0), priority order:
  1. `upd_valid` and `upd_mispredict`: GHR <= {`upd_ghr`[`IDX_W`-2:0], `upd_taken`} if conditional, else GHR <= `upd_ghr`.
  2. Else if `fetch_en`, hit and `is_cond`: GHR <= {GHR[`IDX_W`-2:0], `pred_taken`}.
  3. Else hold.
- **Same-cycle lookup and update to the same index.** The lookup sees the pre-update contents; the new values are visible the next cycle.

## Timing

- Reset values: `init_done`=0, `pred_taken`=0, `pred_target`=`pc_if`+4, `pred_ghr`=0.
- `init_done` rises exactly `ENTRIES` cycles after the last reset cycle; the first valid prediction is in that cycle.
- Lookup latency: 0 cycles (combinational from registered tables).
- Update effect: visible to a lookup 1 cycle after the `upd_valid` edge.
- Misprediction recovery, flushing and `PC_new` muxing belong to the CPU; this block only exposes the prediction.

## Structure

- Package `bp_pkg`:
  - counter encodings `CTR_SNT`..`CTR_ST`;
  - state enum `BP_INIT`/`BP_RUN`;
  - functions `ctr_inc`/`ctr_dec` (saturating).
- Sub-module `bp_pht`: counter array with one read port (lookup), one read-modify-write port (update) and a sweep-clear port. The BTB arrays and GHR stay in the top.

## Test plan

1. **Reset sweep.** `ENTRIES`=16: assert `reset` 1 cycle -> `init_done`=0 for 16 cycles, then 1. Re-assert reset at sweep cycle 7 -> 16 further cycles before `init_done`.
2. **Allocation and prediction.** Update `upd_pc`=0x40, conditional, taken, target 0x80 -> next cycle `pc_if`=0x40 gives `pred_taken`=1, `pred_target`=0x80.
3. **Saturation.** Two not-taken updates at 0x40 -> `pred_taken`=0 (counter 00). A further not-taken update stays at 00. One taken -> 01, still not taken; a second taken -> 10, predicts taken.
4. **Tag alias.** 0x40 is allocated; lookup `pc_if`=0x440 (same index, different tag) -> `pred_taken`=0, `pred_target`=0x444.
5. **Jump.** `j` at 0x10 updated taken to 0x200 -> always predicted taken with target 0x200, regardless of counter value.
6. **Gshare GHR.** `MODE`=1: two predicted-taken hits with `fetch_en`=1 -> GHR=0b11. A hit with `fetch_en`=0 leaves GHR unchanged. A mispredict with `upd_ghr`=0b0101, conditional, not taken -> GHR=0b1010, with priority over a simultaneous speculative shift.
